// File: rtl/mips_fetch_pkg.sv
// Purpose : shared types and constants for the MIPS instruction-fetch stage.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: FSM state enum, default reset PC, instruction field positions,
//           and a helper that builds the sign-extended, word-scaled branch
//           offset from an I-type instruction.
package mips_fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instruction field positions (MIPS32 encoding)
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int IMM_MSB   = 15;
   localparam int JTARG_MSB = 25;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // {14 x sign, imm16, 2'b00}: the immediate is a word offset, so it is
   // shifted left by two after sign extension to a full 32-bit byte offset.
   function automatic logic [XLEN-1:0] branch_offset(input logic [XLEN-1:0] instr);
      return {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
   endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Purpose : next-PC selection for the fetch stage (jump > branch > sequential).
// Latency : purely combinational, zero cycles.
// Backpr. : none; consumer decides when next_pc is sampled.
//
// Ports:
//   pcplus4  in  32  address of the current instruction + 4
//   instr    in  32  current instruction word
//   pcsrc    in  1   branch taken
//   jump     in  1   jump
//   next_pc  out 32  selected next fetch address
module mips_next_pc (
   input  logic [31:0] pcplus4,
   input  logic [31:0] instr,
   input  logic        pcsrc,
   input  logic        jump,
   output logic [31:0] next_pc
);
   import mips_fetch_pkg::*;

   logic [31:0] w_branch_target;
   logic [31:0] w_jump_target;

   // Branch target is relative to the delay-free pc+4; wraps modulo 2^32.
   assign w_branch_target = pcplus4 + branch_offset(instr);

   // Jump keeps the 256 MB region of pc+4 and replaces the rest.
   assign w_jump_target = {pcplus4[31:28], instr[JTARG_MSB:0], 2'b00};

   // Jump has priority when the controller raises both.
   always_comb begin
      next_pc = pcplus4;
      if (jump) begin
         next_pc = w_jump_target;
      end else if (pcsrc) begin
         next_pc = w_branch_target;
      end
   end

endmodule

// File: rtl/mips_fetch_unit.sv
// Purpose : MIPS fetch stage: PC, single-outstanding imem req/ack, instr hold.
// Latency : instr_valid one cycle after imem_ack; req again one cycle after advance.
// Backpr. : req held stable until ack; instr held until advance (ignored when invalid).
//
// Ports:
//   clk, reset             core clock, asynchronous active-high reset
//   imem_req/addr          fetch request and its address (= pc)
//   imem_ack/rdata         one-cycle ack with the instruction word
//   advance, pcsrc, jump   retire strobe plus controller's next-PC decisions
//   instr_valid, instr     registered instruction and its valid flag
//   op, funct              opcode / function slices of instr
//   pc, pcplus4            current instruction address and pc + 4
//   retired_count          wrapping count of retired instructions
module mips_fetch_unit #(
   parameter int                XLEN     = mips_fetch_pkg::XLEN,
   parameter logic [XLEN-1:0]   RESET_PC = mips_fetch_pkg::DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            advance,
   input  logic            pcsrc,
   input  logic            jump,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [5:0]      op,
   output logic [5:0]      funct,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pcplus4,
   output logic [XLEN-1:0] retired_count
);
   import mips_fetch_pkg::*;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;
   logic            r_instr_vld;
   logic [XLEN-1:0] r_retired;
   logic [XLEN-1:0] w_pcplus4;
   logic [XLEN-1:0] w_next_pc;
   logic            w_fetch_done;
   logic            w_retire;

   assign w_pcplus4 = r_pc + XLEN'(4);

   // Only a valid instruction can retire, so advance/pcsrc/jump are
   // meaningless outside HOLD.
   assign w_fetch_done = (r_state == FETCH) && imem_ack;
   assign w_retire     = (r_state == HOLD) && advance;

   mips_next_pc u_next_pc (
      .pcplus4 (w_pcplus4),
      .instr   (r_instr),
      .pcsrc   (pcsrc),
      .jump    (jump),
      .next_pc (w_next_pc)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RST;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // imem_req decodes straight from the state register, so an async reset
   // drops it in the same cycle and abandons any outstanding request.
   always_comb begin
      w_state_nxt = r_state;
      imem_req    = 1'b0;
      case (r_state)
         RST: begin
            w_state_nxt = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (advance) begin
               w_state_nxt = FETCH;
            end
         end
         default: begin
            w_state_nxt = RST;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // PC, instruction register and retire counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_instr     <= '0;
         r_instr_vld <= 1'b0;
         r_retired   <= '0;
      end else begin
         if (w_fetch_done) begin
            r_instr     <= imem_rdata;
            r_instr_vld <= 1'b1;
         end
         if (w_retire) begin
            r_pc        <= w_next_pc;
            r_instr_vld <= 1'b0;
            r_retired   <= r_retired + XLEN'(1);
         end
      end
   end

   assign imem_addr     = r_pc;
   assign pc            = r_pc;
   assign pcplus4       = w_pcplus4;
   assign instr         = r_instr;
   assign instr_valid   = r_instr_vld;
   assign retired_count = r_retired;

   // Pure slices of a register: no combinational glitches reach the decoder.
   assign op    = r_instr[OP_MSB:OP_LSB];
   assign funct = r_instr[FUNCT_MSB:0];

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction-fetch stage of the MIPS core. It holds the PC, fetches one instruction at a time from instruction memory over a req/ack handshake, and presents op/funct/instr to the main controller and datapath. When the datapath retires the instruction, the unit consumes the controller's pcsrc/jump decisions to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
XLEN, 32, address/data width (fixed at 32; parameterised only for the package constant)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  32  fetch address (= pc), stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid in that cycle; may arrive in the same cycle as req
imem_rdata  in  32  instruction word
advance  in  1  datapath retires the current instruction this cycle
pcsrc  in  1  branch taken (controller), sampled only on a valid advance
jump  in  1  jump (controller), sampled only on a valid advance
instr_valid  out  1  instr/op/funct hold a fetched instruction
instr  out  32  registered instruction
op  out  6  instr[31:26]
funct  out  6  instr[5:0]
pc  out  32  address of the current instruction
pcplus4  out  32  pc + 4, modulo 2^32
retired_count  out  32  number of retired instructions, wraps

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=RST, imem_req=0, instr_valid=0, instr=0, retired_count=0.
  - Instruction memory shares the same reset, so no stale ack can follow reset.
- FSM states: RST, FETCH, HOLD.
- RST: on the first clock edge with reset low, go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc; pc is frozen.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to HOLD. imem_req is low from the next cycle.
  - Without ack: stay in FETCH indefinitely; imem_req and imem_addr stay stable.
- HOLD:
  - instr, op, funct and pc stay stable.
  - On advance=1: pc<=next_pc, instr_valid<=0, retired_count<=retired_count+1, go to FETCH.
- advance, pcsrc and jump are ignored whenever instr_valid=0.
- next_pc priority:
  1. jump: {pcplus4[31:28], instr[25:0], 2'b00}
  2. pcsrc: pcplus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  3. otherwise: pcplus4
- Arithmetic: all 32-bit, wrap modulo 2^32, no overflow flag. pc[1:0] is always 00.
- Latency:
  - Best case (ack in the req cycle, advance in the first HOLD cycle) is 1 instruction per 2 cycles.
  - instr_valid rises the cycle after the ack.
  - imem_req re-asserts the cycle after advance.
- Simultaneous pcsrc=1 and jump=1: jump wins.
- Reset asserted in FETCH: imem_req drops combinationally-from-state within the same cycle (async), and the outstanding request is abandoned.
- Outputs op and funct are pure slices of the registered instr, so they are glitch-free.

Decomposition:
- Package mips_fetch_pkg:
  - state enum {RST, FETCH, HOLD}
  - DEFAULT_RESET_PC
  - field positions: OP_MSB=31, OP_LSB=26, FUNCT_MSB=5, IMM_MSB=15, JTARG_MSB=25
- One combinational sub-module, mips_next_pc:
  - inputs: pcplus4, instr, pcsrc, jump
  - output: next_pc
  - unit-testable on its own
- FSM, PC register, instr register and counter stay in the top.

Test Plan:
- Reset then release, memory acks in the same cycle as req → imem_addr=0x0, instr_valid=1 one cycle later; advance with pcsrc=jump=0 → pc=0x4, retired_count=1.
- Branch: instr=0x10000003 at pc=0x0, advance with pcsrc=1 → pc=0x10.
- Jump: instr=0x08000040 at pc=0x10, advance with jump=1 and pcsrc=1 → pc=0x100 (jump wins).
- Backward branch: imm=0xFFFF at pc=0x100, pcsrc=1 → pc=0x100 (loop); then ack delayed 3 cycles → imem_req held 4 cycles, imem_addr stable at 0x100, instr_valid=0 throughout, advance pulses ignored.
- Wrap: RESET_PC=0xFFFFFFFC, advance with no branch → pc=0x00000000, pcplus4=0x4.
- Reset asserted mid-FETCH → imem_req=0 and pc=RESET_PC before the next edge; instr_valid=0; fetch restarts one cycle after release.
